if_stage: RTL

// - Instruction-fetch stage of the pipelined MIPS core; sits directly upstream of IM.
// - Holds the PC and drives IM's 10-bit word address. Latches IM's combinational instr into the IF/ID register.
// - Computes the next PC from sequential, branch, jump and register-jump requests issued by ID.
// - Supports stall (hazard unit) and flush (exception/eret) control.

---
 rtl/if_stage_if.sv | 31 +++
 rtl/if_stage.sv | 98 +++++++++
 2 files changed

// File: rtl/if_stage_if.sv
// Bundle of the IF stage's control, IM and IF/ID signals.
// The slave modport is the fetch stage; the master modport is ID, hazard unit and IM.
interface if_stage_if #(
  parameter int IM_AW = 10
);
  logic             stall;
  logic             flush;
  logic [1:0]       npc_sel;
  logic             br_taken;
  logic [15:0]      br_imm16;
  logic [25:0]      j_index;
  logic [31:0]      jr_target;
  logic [IM_AW-1:0] imem_addr;
  logic [31:0]      imem_instr;
  logic [31:0]      pc;
  logic [31:0]      id_instr;
  logic [31:0]      id_pc;
  logic [31:0]      id_pc8;
  logic             id_valid;
  logic             fetch_err;

  modport slave (
    input  stall, flush, npc_sel, br_taken, br_imm16, j_index, jr_target, imem_instr,
    output imem_addr, pc, id_instr, id_pc, id_pc8, id_valid, fetch_err
  );

  modport master (
    output stall, flush, npc_sel, br_taken, br_imm16, j_index, jr_target, imem_instr,
    input  imem_addr, pc, id_instr, id_pc, id_pc8, id_valid, fetch_err
  );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection and the IF/ID register.
// Branch and jump targets are formed from the delay-slot PC (id_pc + 4).
module if_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
  parameter int          IM_AW    = 10
) (
  input  logic     clk,
  input  logic     rst_n,
  if_stage_if.slave bus
);

  localparam logic [31:0] PC_END = PC_RESET + (32'd4 << IM_AW);

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;

  function automatic logic [31:0] f_branch_target(input logic [31:0] id_pc4,
                                                  input logic [15:0] imm);
    return id_pc4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

  function automatic logic [31:0] f_jump_target(input logic [31:0] id_pc4,
                                                input logic [25:0] idx);
    return {id_pc4[31:28], idx, 2'b00};
  endfunction

  function automatic logic f_fetch_err(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < PC_RESET) || (pc >= PC_END);
  endfunction

  logic [31:0] r_pc;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc;
  logic        r_id_valid;

  logic [31:0] w_pc_off;
  logic [31:0] w_pc4;
  logic [31:0] w_id_pc4;
  logic [31:0] w_npc;
  logic        w_fetch_err;
  npc_sel_e    w_sel;

  assign w_pc_off    = r_pc - PC_RESET;
  assign w_pc4       = r_pc + 32'd4;
  assign w_id_pc4    = r_id_pc + 32'd4;
  assign w_fetch_err = f_fetch_err(r_pc);
  assign w_sel       = npc_sel_e'(bus.npc_sel);

  always_comb begin
    w_npc = w_pc4;
    unique case (w_sel)
      NPC_SEQ: w_npc = w_pc4;
      NPC_BR:  w_npc = bus.br_taken ? f_branch_target(w_id_pc4, bus.br_imm16) : w_pc4;
      NPC_J:   w_npc = f_jump_target(w_id_pc4, bus.j_index);
      NPC_JR:  w_npc = bus.jr_target;
      default: w_npc = w_pc4;
    endcase
  end

  // Flush outranks stall; a faulting fetch turns into a bubble tagged with its PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= PC_RESET;
      r_id_instr <= 32'd0;
      r_id_pc    <= PC_RESET;
      r_id_valid <= 1'b0;
    end else if (bus.flush) begin
      r_pc       <= EXC_VEC;
      r_id_instr <= 32'd0;
      r_id_pc    <= r_pc;
      r_id_valid <= 1'b0;
    end else if (!bus.stall) begin
      r_pc    <= w_npc;
      r_id_pc <= r_pc;
      if (w_fetch_err) begin
        r_id_instr <= 32'd0;
        r_id_valid <= 1'b0;
      end else begin
        r_id_instr <= bus.imem_instr;
        r_id_valid <= 1'b1;
      end
    end
  end

  assign bus.imem_addr = w_pc_off[IM_AW+1:2];
  assign bus.pc        = r_pc;
  assign bus.id_instr  = r_id_instr;
  assign bus.id_pc     = r_id_pc;
  assign bus.id_pc8    = r_id_pc + 32'd8;
  assign bus.id_valid  = r_id_valid;
  assign bus.fetch_err = w_fetch_err;

endmodule
